// File: rtl/ecall_io_ctrl.sv
// rtl/ecall_io_ctrl.sv - ecall service controller bridging the core to switches, button and display
//
// Serves MiniRiscV ecall requests against board I/O:
//   1 print (waits for a confirm press), 5 read switches unsigned,
//   6 read switches signed, 11 print without waiting, 10 halt,
//   anything else flags err and completes at once.
//
// Ports:
//   clk_slow      block clock
//   rst           synchronous, active-low reset
//   ecall         request level, held by the core until it sees ecall_done
//   a0, a7        service argument and service number
//   switches      raw switch levels, sampled when a read completes
//   button        raw asynchronous confirm button
//   ecall_done    one-cycle completion pulse
//   ecall_write   with ecall_done: ecall_result must be written to a0
//   ecall_result  result word, holds until the next completion
//   seg_data      display word, holds until the next print
//   halted        sticky halt flag
//   err           sticky unknown-service flag

module ecall_io_ctrl #(
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk_slow,
  input  logic                rst,
  input  logic                ecall,
  input  logic [31:0]         a0,
  input  logic [31:0]         a7,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                button,
  output logic                ecall_done,
  output logic                ecall_write,
  output logic [31:0]         ecall_result,
  output logic [31:0]         seg_data,
  output logic                halted,
  output logic                err
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE, S_HALT} state_t;
  typedef enum logic [1:0] {K_PRINT, K_READ_U, K_READ_S} kind_t;

  // ---------------------------------------------------------------
  // Button path: synchroniser, debounce, rising-edge pulse
  // ---------------------------------------------------------------
  logic          sync1;
  logic          btn_s;
  logic          btn_db;
  logic          btn_db_q;
  logic [CW-1:0] cnt;
  logic          press;

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      sync1    <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= button;
      btn_s <= sync1;
      // Accept a new level only after it has differed from the debounced
      // level on DEBOUNCE_CYCLES consecutive edges; any agreement restarts.
      if (btn_s != btn_db) begin
        if (cnt == CNT_LAST) begin
          btn_db <= btn_s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      btn_db_q <= btn_db;
      press    <= btn_db & ~btn_db_q;
    end
  end

  // ---------------------------------------------------------------
  // Switch views for the two read services
  // ---------------------------------------------------------------
  logic [31:0] sw_u;
  logic [31:0] sw_s;

  always_comb begin
    sw_u                 = '0;
    sw_u[SW_WIDTH-1:0]   = switches;
    sw_s                 = {32{switches[SW_WIDTH-1]}};
    sw_s[SW_WIDTH-1:0]   = switches;
  end

  // ---------------------------------------------------------------
  // Service FSM; all outputs are registered alongside the state
  // ---------------------------------------------------------------
  state_t      state, state_n;
  kind_t       kind, kind_n;
  logic        done_n;
  logic        write_n;
  logic [31:0] result_n;
  logic [31:0] seg_n;
  logic        halted_n;
  logic        err_n;

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state        <= S_IDLE;
      kind         <= K_PRINT;
      ecall_done   <= 1'b0;
      ecall_write  <= 1'b0;
      ecall_result <= '0;
      seg_data     <= '0;
      halted       <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      kind         <= kind_n;
      ecall_done   <= done_n;
      ecall_write  <= write_n;
      ecall_result <= result_n;
      seg_data     <= seg_n;
      halted       <= halted_n;
      err          <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    kind_n   = kind;
    done_n   = 1'b0;
    write_n  = 1'b0;
    result_n = ecall_result;
    seg_n    = seg_data;
    halted_n = halted;
    err_n    = err;

    case (state)
      S_IDLE: begin
        if (ecall && !halted) begin
          case (a7)
            32'd1: begin
              seg_n   = a0;
              kind_n  = K_PRINT;
              state_n = S_WAIT;
            end
            32'd5: begin
              kind_n  = K_READ_U;
              state_n = S_WAIT;
            end
            32'd6: begin
              kind_n  = K_READ_S;
              state_n = S_WAIT;
            end
            32'd11: begin
              seg_n   = a0;
              done_n  = 1'b1;
              state_n = S_RELEASE;
            end
            32'd10: begin
              halted_n = 1'b1;
              state_n  = S_HALT;
            end
            default: begin
              err_n    = 1'b1;
              done_n   = 1'b1;
              result_n = '0;
              state_n  = S_RELEASE;
            end
          endcase
        end
      end

      S_WAIT: begin
        // Only a fresh debounced rising edge completes; a button already
        // held when WAIT was entered produces no press pulse.
        if (press) begin
          done_n = 1'b1;
          case (kind)
            K_READ_U: begin
              write_n  = 1'b1;
              result_n = sw_u;
            end
            K_READ_S: begin
              write_n  = 1'b1;
              result_n = sw_s;
            end
            default: begin
              result_n = '0;
            end
          endcase
          state_n = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // Wait for the core to drop the request so it cannot re-trigger.
        if (!ecall) state_n = S_IDLE;
      end

      default: begin
        state_n = S_HALT;
      end
    endcase
  end

endmodule
